// File: rtl/gpo_sched_pkg.sv
// Shared definitions for the GPO event scheduler: FSM states, event word layout
// and default queue depth.
package gpo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_FIRE = 2'd3
    } sched_state_e;

    localparam int EVENT_WIDTH        = 128;
    localparam int TS_MSB             = 127;
    localparam int TS_LSB             = 64;
    localparam int DATA_MSB           = 63;
    localparam int DATA_LSB           = 0;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    function automatic logic [TS_MSB-TS_LSB:0] event_ts(input logic [EVENT_WIDTH-1:0] word);
        return word[TS_MSB:TS_LSB];
    endfunction

endpackage

// File: rtl/gpo_event_scheduler_if.sv
// Control, event-write and GPO-issue signals of the scheduler; master drives
// the scheduler inputs, slave is the scheduler itself.
interface gpo_event_scheduler_if #(
    parameter int FIFO_DEPTH = gpo_sched_pkg::DEFAULT_FIFO_DEPTH,
    parameter int TS_WIDTH   = 64
);
    import gpo_sched_pkg::*;

    logic                         timer_run;
    logic                         timer_clear;
    logic                         wr_en;
    logic [EVENT_WIDTH-1:0]       wr_data;
    logic                         flush;
    logic                         busy;
    logic                         counter_matched;
    logic [EVENT_WIDTH-1:0]       gpo_out;
    logic                         late_error;
    logic                         overflow_error;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic [TS_WIDTH-1:0]          timer;

    modport master (
        output timer_run, timer_clear, wr_en, wr_data, flush, busy,
        input  counter_matched, gpo_out, late_error, overflow_error,
               fifo_full, fifo_empty, fifo_level, timer
    );

    modport slave (
        input  timer_run, timer_clear, wr_en, wr_data, flush, busy,
        output counter_matched, gpo_out, late_error, overflow_error,
               fifo_full, fifo_empty, fifo_level, timer
    );

endinterface

// File: rtl/gpo_sched_fifo.sv
// Event queue: RAM-style storage with a registered read port, so popped data
// appears on o_rd_data the cycle after i_rd_en.
module gpo_sched_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_flush,
    input  logic                      i_wr_en,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic                      i_rd_en,
    output logic [WIDTH-1:0]          o_rd_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rd_data = r_rd_data;

    // A pop frees a slot in the same cycle, so a full queue still accepts a write then.
    assign w_pop  = i_rd_en && !o_empty && !i_flush;
    assign w_push = i_wr_en && !i_flush && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
        if (w_pop)  r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/gpo_event_scheduler.sv
// Timestamped GPO event scheduler: queues event words and issues each one to
// the GPO core once the free-running timer reaches its timestamp.
module gpo_event_scheduler #(
    parameter int FIFO_DEPTH = gpo_sched_pkg::DEFAULT_FIFO_DEPTH,
    parameter int TS_WIDTH   = 64
) (
    input  logic                  CLK100MHZ,
    input  logic                  resetn,
    gpo_event_scheduler_if.slave  bus
);
    import gpo_sched_pkg::*;

    sched_state_e                 r_state;
    logic [TS_WIDTH-1:0]          r_timer;
    logic [EVENT_WIDTH-1:0]       r_stage;
    logic [EVENT_WIDTH-1:0]       r_gpo_out;
    logic                         r_matched;
    logic                         r_late;
    logic                         r_overflow;

    logic [EVENT_WIDTH-1:0]       w_fifo_rd_data;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_level;
    logic                         w_pop;
    logic                         w_drop;
    logic [TS_WIDTH-1:0]          w_stage_ts;
    logic                         w_due;
    logic                         w_past_due;

    gpo_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_WIDTH)
    ) u_fifo (
        .clk       (CLK100MHZ),
        .rst_n     (resetn),
        .i_flush   (bus.flush),
        .i_wr_en   (bus.wr_en),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // Head is popped from IDLE or FIRE; the registered read data is ready in LOAD.
    assign w_pop      = ((r_state == ST_IDLE) || (r_state == ST_FIRE)) && !w_empty && !bus.flush;
    assign w_drop     = bus.wr_en && !bus.flush && w_full && !w_pop;
    assign w_stage_ts = TS_WIDTH'(event_ts(r_stage));
    assign w_due      = !bus.busy && (r_timer >= w_stage_ts);
    assign w_past_due = (r_timer > w_stage_ts);

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (bus.timer_clear) begin
            r_timer <= '0;
        end else if (bus.timer_run) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_stage    <= '0;
            r_gpo_out  <= '0;
            r_matched  <= 1'b0;
            r_late     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_matched  <= 1'b0;
            r_late     <= 1'b0;
            r_overflow <= w_drop;
            if (bus.flush) begin
                r_state <= ST_IDLE;
                r_stage <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_pop) r_state <= ST_LOAD;
                    ST_LOAD: begin
                        r_stage <= w_fifo_rd_data;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: if (w_due) begin
                        r_state   <= ST_FIRE;
                        r_matched <= 1'b1;
                        r_late    <= w_past_due;
                        r_gpo_out <= r_stage;
                    end
                    ST_FIRE: r_state <= w_pop ? ST_LOAD : ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.counter_matched = r_matched;
    assign bus.gpo_out         = r_gpo_out;
    assign bus.late_error      = r_late;
    assign bus.overflow_error  = r_overflow;
    assign bus.fifo_full       = w_full;
    assign bus.fifo_empty      = w_empty;
    assign bus.fifo_level      = w_level;
    assign bus.timer           = r_timer;

endmodule

// File: tb/tb_gpo_event_scheduler.sv
// Directed bench for gpo_event_scheduler: on-time, late, busy-held, overflow,
// flush and mid-queue reset scenarios with hand-computed expectations.
module tb_gpo_event_scheduler;
    import gpo_sched_pkg::*;

    localparam int DEPTH = 16;
    localparam int TSW   = 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gpo_event_scheduler_if #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

    gpo_event_scheduler #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .CLK100MHZ (clk),
        .resetn    (resetn),
        .bus       (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [63:0] timer_prev = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; samples land 1 ns after the rising edge.
    task automatic step();
        timer_prev = bus.timer;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_ev(input logic [63:0] ts, input logic [63:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_data = {ts, data};
    endtask

    task automatic note_issue();
        $display("cycle %0d issue word=0x%032h late=%0b timer=%0d",
                 cyc, bus.gpo_out, bus.late_error, bus.timer);
    endtask

    // Steps until counter_matched is seen; n = steps taken, or -1 if the budget ran out.
    task automatic wait_fire(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (bus.counter_matched === 1'b1) begin
                n = i;
                note_issue();
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int last;
        int bad_order;
        int bad_gap;
        logic [63:0] fired_t;
        logic        fired_late;
        logic [63:0] fired_data;

        bus.timer_run = 1'b0; bus.timer_clear = 1'b0; bus.wr_en = 1'b0;
        bus.wr_data = '0; bus.flush = 1'b0; bus.busy = 1'b0;

        // Reset state
        step(); step();
        chk("rst_matched",  128'(bus.counter_matched), 128'(0));
        chk("rst_gpo_out",  bus.gpo_out, 128'(0));
        chk("rst_late",     128'(bus.late_error), 128'(0));
        chk("rst_overflow", 128'(bus.overflow_error), 128'(0));
        chk("rst_empty",    128'(bus.fifo_empty), 128'(1));
        chk("rst_full",     128'(bus.fifo_full), 128'(0));
        chk("rst_level",    128'(bus.fifo_level), 128'(0));
        chk("rst_timer",    128'(bus.timer), 128'(0));

        // On-time event: ts=20 written at cycle 2 with timer running from 0
        resetn = 1'b1;
        bus.timer_run = 1'b1;
        step(); step();
        chk("A_timer_run", 128'(bus.timer), 128'(2));
        write_ev(64'd20, 64'hA5);
        step();
        bus.wr_en = 1'b0;
        chk("A_level", 128'(bus.fifo_level), 128'(1));
        wait_fire(40, n);
        chk("A_decision_timer", 128'(timer_prev), 128'(20));
        chk("A_late", 128'(bus.late_error), 128'(0));
        chk("A_data", 128'(bus.gpo_out[63:0]), 128'(64'hA5));
        chk("A_ts",   128'(bus.gpo_out[127:64]), 128'(64'd20));
        step();
        chk("A_single_pulse", 128'(bus.counter_matched), 128'(0));
        chk("A_hold", bus.gpo_out, {64'd20, 64'hA5});

        // Past-due event written at timer=100 fires 4 cycles later, flagged late
        bus.timer_clear = 1'b1;
        step();
        bus.timer_clear = 1'b0;
        chk("B_clear_priority", 128'(bus.timer), 128'(0));
        for (int i = 0; i < 100; i++) step();
        chk("B_timer100", 128'(bus.timer), 128'(100));
        write_ev(64'd50, 64'h5A);
        step();
        bus.wr_en = 1'b0;
        wait_fire(10, n);
        chk("B_latency", 128'(1 + n), 128'(4));
        chk("B_late", 128'(bus.late_error), 128'(1));
        chk("B_data", 128'(bus.gpo_out[63:0]), 128'(64'h5A));
        chk("B_fire_timer", 128'(bus.timer), 128'(104));

        // Busy held while timer reads 8..15; ts=10 fires once busy drops
        bus.timer_clear = 1'b1;
        step();
        bus.timer_clear = 1'b0;
        write_ev(64'd10, 64'hC3);
        step();
        bus.wr_en = 1'b0;
        fired_t = '1; fired_late = 1'b0; fired_data = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.counter_matched === 1'b1) begin
                fired_t = bus.timer; fired_late = bus.late_error;
                fired_data = bus.gpo_out[63:0];
                note_issue();
                break;
            end
            bus.busy = (bus.timer >= 64'd8) && (bus.timer <= 64'd15);
        end
        bus.busy = 1'b0;
        chk("C_fire_timer", 128'(fired_t), 128'(17));
        chk("C_late", 128'(fired_late), 128'(1));
        chk("C_data", 128'(fired_data), 128'(64'hC3));

        // Overflow: one staged event plus 16 queued, 17th queued write dropped
        bus.busy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            write_ev(64'd0, 64'(i));
            if (i == 17) chk("D_full_before", 128'(bus.fifo_full), 128'(1));
            step();
        end
        bus.wr_en = 1'b0;
        chk("D_overflow", 128'(bus.overflow_error), 128'(1));
        chk("D_level", 128'(bus.fifo_level), 128'(16));
        chk("D_full", 128'(bus.fifo_full), 128'(1));
        step();
        chk("D_overflow_pulse", 128'(bus.overflow_error), 128'(0));
        bus.busy = 1'b0;
        cnt = 0; last = 0; bad_order = 0; bad_gap = 0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (bus.counter_matched === 1'b1) begin
                note_issue();
                if (bus.gpo_out[63:0] != 64'(cnt)) bad_order++;
                if (cnt > 0 && (cyc - last) != 3) bad_gap++;
                last = cyc;
                cnt++;
            end
        end
        chk("D_issue_count", 128'(cnt), 128'(17));
        chk("D_order", 128'(bad_order), 128'(0));
        chk("D_spacing", 128'(bad_gap), 128'(0));
        chk("D_drained", 128'(bus.fifo_empty), 128'(1));

        // Flush in WAIT with a due decision and a coincident write
        bus.busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_ev(64'd0, 64'hE0 + 64'(i));
            step();
        end
        bus.wr_en = 1'b0;
        step(); step(); step();
        bus.busy = 1'b0;
        bus.flush = 1'b1;
        write_ev(64'd0, 64'hEF);
        step();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        chk("E_empty", 128'(bus.fifo_empty), 128'(1));
        chk("E_level", 128'(bus.fifo_level), 128'(0));
        chk("E_state", 128'(dut.r_state), 128'(ST_IDLE));
        chk("E_matched", 128'(bus.counter_matched), 128'(0));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.counter_matched === 1'b1) cnt++;
        end
        chk("E_no_pulse", 128'(cnt), 128'(0));

        // Three due events back to back, then asynchronous reset mid-queue
        for (int i = 0; i < 3; i++) begin
            write_ev(64'd0, 64'hB0 + 64'(i));
            step();
        end
        bus.wr_en = 1'b0;
        wait_fire(10, n);
        chk("F_first_latency", 128'(3 + n), 128'(4));
        chk("F_data0", 128'(bus.gpo_out[63:0]), 128'(64'hB0));
        wait_fire(10, n);
        chk("F_gap", 128'(n), 128'(3));
        chk("F_data1", 128'(bus.gpo_out[63:0]), 128'(64'hB1));
        #3;
        resetn = 1'b0;
        #1;
        chk("F_rst_matched", 128'(bus.counter_matched), 128'(0));
        chk("F_rst_gpo_out", bus.gpo_out, 128'(0));
        chk("F_rst_timer", 128'(bus.timer), 128'(0));
        chk("F_rst_empty", 128'(bus.fifo_empty), 128'(1));
        chk("F_rst_level", 128'(bus.fifo_level), 128'(0));
        step(); step();
        chk("F_rst_late", 128'(bus.late_error), 128'(0));
        chk("F_rst_overflow", 128'(bus.overflow_error), 128'(0));
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.counter_matched === 1'b1) cnt++;
        end
        chk("F_quiet_after_reset", 128'(cnt), 128'(0));
        chk("F_gpo_still_zero", bus.gpo_out, 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
